// File: rtl/fetch_pc_queue.sv
// Fetch front end: PC register, 2-cycle imem in-flight tracker and a
// 3-entry {pc, inst} result queue feeding decode; squashes on redirect.
module fetch_pc_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    output logic             valid_o,
    output logic [31:0]      inst_o,
    output logic [WIDTH-1:0] pc_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s1_pc_q, s1_pc_d, s2_pc_q, s2_pc_d;
    logic [WIDTH-1:0] fpc_q [3];
    logic [31:0]      finst_q [3];
    logic [1:0]       rd_q, rd_d, occ_q, occ_d, wr_idx;
    logic             pop, push;
    logic [2:0]       used, wsum;

    assign valid_o     = (occ_q != 2'd0);
    assign inst_o      = valid_o ? finst_q[rd_q] : NOP;
    assign pc_o        = valid_o ? fpc_q[rd_q] : '0;
    assign imem_addr_o = pc_q;

    always_comb begin
        pop  = valid_o & ~stall_i & ~redirect_i;
        push = s2_v_q & ~redirect_i;
        // Queue slots already promised: entries held plus requests in flight.
        used = {1'b0, occ_q} + {2'b0, s1_v_q} + {2'b0, s2_v_q} - {2'b0, pop};
        imem_req_o = ~reset & ~redirect_i & (used <= 3'd2);
        wsum   = {1'b0, rd_q} + {1'b0, occ_q};
        wr_idx = (wsum >= 3'd3) ? 2'(wsum - 3'd3) : wsum[1:0];

        pc_d    = imem_req_o ? pc_q + PC_INC : pc_q;
        s1_v_d  = imem_req_o;
        s1_pc_d = pc_q;
        s2_v_d  = s1_v_q;
        s2_pc_d = s1_pc_q;
        rd_d    = pop ? ((rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1) : rd_q;
        occ_d   = occ_q + {1'b0, push} - {1'b0, pop};

        if (redirect_i) begin
            pc_d   = redirect_pc_i;
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
            rd_d   = 2'd0;
            occ_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            s1_v_q  <= 1'b0;
            s1_pc_q <= '0;
            s2_v_q  <= 1'b0;
            s2_pc_q <= '0;
            rd_q    <= 2'd0;
            occ_q   <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            s1_v_q  <= s1_v_d;
            s1_pc_q <= s1_pc_d;
            s2_v_q  <= s2_v_d;
            s2_pc_q <= s2_pc_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                fpc_q[i]   <= '0;
                finst_q[i] <= NOP;
            end
        end else if (push) begin
            fpc_q[wr_idx]   <= s2_pc_q;
            finst_q[wr_idx] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: 2-cycle memory model plus a fetch-stream
// reference (pending fetches with ready times) under random stall/redirect.
module tb_fetch_pc_queue;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    fetch_pc_queue #(
        .WIDTH(32),
        .RESET_PC(RST_PC),
        .PC_INC(32'd4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o),
        .inst_o(inst_o),
        .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    // Memory returns mem[a] = a ^ KEY two cycles after the request cycle.
    logic [31:0] h1 = '0, h2 = '0;
    always @(posedge clk) begin
        h1 <= imem_addr_o;
        h2 <= h1;
    end
    assign imem_rdata_i = h2 ^ KEY;

    typedef struct {
        logic [31:0] pc;
        int          rdy;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    logic [31:0] nxt = RST_PC;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cyc=%0d: got %h expected %h",
                         tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic rd,
                        input logic [31:0] rpc);
        logic vexp, pop, rexp;
        @(negedge clk);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #1;
        vexp = (q.size() > 0) && (q[0].rdy <= cyc);
        chk("valid", {31'b0, valid_o}, {31'b0, vexp});
        if (vexp) begin
            chk("pc", pc_o, q[0].pc);
            chk("inst", inst_o, q[0].pc ^ KEY);
        end else begin
            chk("pc_idle", pc_o, 32'h0);
            chk("inst_idle", inst_o, NOP);
        end
        pop  = vexp & ~st & ~rd;
        rexp = ~rd && ((q.size() - int'(pop)) <= 2);
        chk("req", {31'b0, imem_req_o}, {31'b0, rexp});
        if (rexp) chk("addr", imem_addr_o, nxt);
        if (rd) begin
            q.delete();
            nxt = rpc;
        end else begin
            if (pop) void'(q.pop_front());
            if (rexp) begin
                q.push_back('{pc: nxt, rdy: cyc + 3});
                nxt = nxt + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset      = 1'b1;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        #1;
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_req", {31'b0, imem_req_o}, 32'h0);
        chk("rst_addr", imem_addr_o, RST_PC);
        @(posedge clk);
        #2;
        reset = 1'b0;
        q.delete();
        nxt = RST_PC;
    endtask

    initial begin
        logic        st, rd;
        logic [31:0] rpc;

        do_reset();
        // Sequential fetch from reset, including the wrap past 2^32.
        repeat (12) step(1'b0, 1'b0, '0);
        // Long stall in steady state, then release.
        repeat (6) step(1'b1, 1'b0, '0);
        repeat (8) step(1'b0, 1'b0, '0);
        // Fill queue and in-flight slots, then redirect.
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0100);
        repeat (8) step(1'b0, 1'b0, '0);
        // Redirect and stall together while a response is returning.
        step(1'b1, 1'b1, 32'h0000_0200);
        repeat (8) step(1'b0, 1'b0, '0);
        // Random traffic.
        repeat (400) begin
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            step(st, rd, rpc);
        end
        // Reset with requests in flight.
        repeat (5) step(1'b0, 1'b0, '0);
        do_reset();
        repeat (10) step(1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
